// File: rtl/logic_operand_sequencer.sv
// Sequential front end for a combinational W-bit logic unit: collects A then B
// from a serial valid/ready bus, registers the unit's result and hands it downstream.
// Optional macro LOGIC_OPSEQ_ZERO_FLAG_EN adds a registered dout_zero flag.
module logic_operand_sequencer #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [W-1:0]     din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  input  logic [W-1:0]     op_result,
  output logic [W-1:0]     dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
`ifdef LOGIC_OPSEQ_ZERO_FLAG_EN
  ,
  output logic             dout_zero
`endif
);

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    EXEC   = 2'd2,
    OUT    = 2'd3
  } state_t;

  state_t state;

  // din_ready is decoded from state alone so it never depends on din_valid.
  assign din_ready = (state == WAIT_A) || (state == WAIT_B);
  assign busy      = (state != WAIT_A);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_A;
      op_a       <= '0;
      op_b       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      op_count   <= '0;
`ifdef LOGIC_OPSEQ_ZERO_FLAG_EN
      dout_zero  <= 1'b0;
`endif
    end else if (clear) begin
      // Abort only the handshake state; operands, result and count are kept.
      state      <= WAIT_A;
      dout_valid <= 1'b0;
`ifdef LOGIC_OPSEQ_ZERO_FLAG_EN
      dout_zero  <= 1'b0;
`endif
    end else begin
      case (state)
        WAIT_A: begin
          if (din_valid && din_ready) begin
            op_a  <= din;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (din_valid && din_ready) begin
            op_b  <= din;
            state <= EXEC;
          end
        end
        EXEC: begin
          dout       <= op_result;
          dout_valid <= 1'b1;
`ifdef LOGIC_OPSEQ_ZERO_FLAG_EN
          dout_zero  <= (op_result == '0);
`endif
          state      <= OUT;
        end
        OUT: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
`ifdef LOGIC_OPSEQ_ZERO_FLAG_EN
            dout_zero  <= 1'b0;
`endif
            op_count   <= op_count + CNT_W'(1);
            state      <= WAIT_A;
          end
        end
        default: state <= WAIT_A;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_operand_sequencer.sv
// Self-checking bench: bitwise XOR as the logic unit, randomized operands and
// stalls checked against a transaction-level model; a CNT_W=2 copy checks wrap.
module tb_logic_operand_sequencer;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic [W-1:0] din;
  logic         din_valid;
  logic         dout_ready;

  logic         din_ready,  din_ready2;
  logic [W-1:0] op_a,       op_a2;
  logic [W-1:0] op_b,       op_b2;
  logic [W-1:0] op_result,  op_result2;
  logic [W-1:0] dout,       dout2;
  logic         dout_valid, dout_valid2;
  logic         busy,       busy2;
  logic [7:0]   op_count;
  logic [1:0]   op_count2;
`ifdef LOGIC_OPSEQ_ZERO_FLAG_EN
  logic         dout_zero,  dout_zero2;
`endif

  // Bench logic unit: bitwise_xor.
  assign op_result  = op_a ^ op_b;
  assign op_result2 = op_a2 ^ op_b2;

  logic_operand_sequencer #(.W(W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .op_a(op_a), .op_b(op_b), .op_result(op_result),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .op_count(op_count)
`ifdef LOGIC_OPSEQ_ZERO_FLAG_EN
    , .dout_zero(dout_zero)
`endif
  );

  logic_operand_sequencer #(.W(W), .CNT_W(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .din(din), .din_valid(din_valid), .din_ready(din_ready2),
    .op_a(op_a2), .op_b(op_b2), .op_result(op_result2),
    .dout(dout2), .dout_valid(dout_valid2), .dout_ready(dout_ready),
    .busy(busy2), .op_count(op_count2)
`ifdef LOGIC_OPSEQ_ZERO_FLAG_EN
    , .dout_zero(dout_zero2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Transaction-level model: last accepted operands, last result, completions.
  logic [W-1:0] exp_a, exp_b, exp_dout;
  int           exp_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    check("idle_din_ready", din_ready, 1);
    check("idle_busy", busy, 0);
    din = a; din_valid = 1'b1;
    @(negedge clk);
    check("op_a_captured", op_a, a);
    check("waitb_din_ready", din_ready, 1);
    check("waitb_busy", busy, 1);
    din = b;
    @(negedge clk);
    check("op_b_captured", op_b, b);
    check("exec_din_ready", din_ready, 0);
    check("exec_dout_valid", dout_valid, 0);
    din = W'($urandom); din_valid = 1'($urandom_range(0, 1));
    dout_ready = 1'b0;
    exp_a = a; exp_b = b; exp_dout = a ^ b;
    @(negedge clk);
    check("out_dout_valid", dout_valid, 1);
    check("out_dout", dout, exp_dout);
    check("out_din_ready", din_ready, 0);
    check("wrap_dout", dout2, exp_dout);
`ifdef LOGIC_OPSEQ_ZERO_FLAG_EN
    check("out_dout_zero", dout_zero, (exp_dout == 0) ? 1 : 0);
`endif
  endtask

  task automatic finish_op(input int stall);
    for (int i = 0; i < stall; i++) begin
      din = W'($urandom); din_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("stall_dout", dout, exp_dout);
      check("stall_dout_valid", dout_valid, 1);
      check("stall_din_ready", din_ready, 0);
    end
    dout_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    check("done_dout_valid", dout_valid, 0);
    check("done_op_count", op_count, exp_cnt % 256);
    check("done_op_count_wrap", op_count2, exp_cnt % 4);
    check("done_busy", busy, 0);
    check("done_op_a_held", op_a, exp_a);
    check("done_op_b_held", op_b, exp_b);
    check("done_dout_held", dout, exp_dout);
`ifdef LOGIC_OPSEQ_ZERO_FLAG_EN
    check("done_dout_zero", dout_zero, 0);
`endif
    dout_ready = 1'b0; din_valid = 1'b0;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    start_op(a, b);
    finish_op(stall);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_op_a"}, op_a, 0);
    check({tag, "_op_b"}, op_b, 0);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_dout_valid"}, dout_valid, 0);
    check({tag, "_op_count"}, op_count, 0);
    check({tag, "_op_count_wrap"}, op_count2, 0);
    check({tag, "_din_ready"}, din_ready, 1);
    check({tag, "_busy"}, busy, 0);
`ifdef LOGIC_OPSEQ_ZERO_FLAG_EN
    check({tag, "_dout_zero"}, dout_zero, 0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    exp_a = '0; exp_b = '0; exp_dout = '0; exp_cnt = 0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_reset");

    // Directed operations.
    do_op(4'b0100, 4'b0011, 0);
    do_op(4'b1111, 4'b1000, 0);
    do_op(4'b0100, 4'b0101, 5);
    do_op(4'b0101, 4'b0101, 1);
    do_op(4'b1000, 4'b1111, 0);

    // clear in WAIT_B: the word offered with clear is dropped, then a fresh pair.
    @(negedge clk);
    din = 4'b1010; din_valid = 1'b1;
    @(negedge clk);
    check("clr_b_op_a", op_a, 4'b1010);
    exp_a = 4'b1010;
    din = 4'b0110; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; din_valid = 1'b0;
    check("clr_b_busy", busy, 0);
    check("clr_b_din_ready", din_ready, 1);
    check("clr_b_op_b_kept", op_b, exp_b);
    check("clr_b_op_count", op_count, exp_cnt % 256);
    do_op(4'b0011, 4'b1100, 2);

    // clear in OUT: result dropped, count unchanged.
    start_op(4'b1001, 4'b0001);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; din_valid = 1'b0;
    check("clr_out_dout_valid", dout_valid, 0);
    check("clr_out_op_count", op_count, exp_cnt % 256);
    check("clr_out_busy", busy, 0);
    check("clr_out_dout_kept", dout, exp_dout);
`ifdef LOGIC_OPSEQ_ZERO_FLAG_EN
    check("clr_out_dout_zero", dout_zero, 0);
`endif
    do_op(4'b0111, 4'b0010, 0);

    // rst_n pulsed in EXEC: outputs must drop without a clock edge.
    @(negedge clk);
    din = 4'b1110; din_valid = 1'b1;
    @(negedge clk);
    din = 4'b0101;
    @(negedge clk);
    check("exec_before_reset_busy", busy, 1);
    din_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    exp_a = '0; exp_b = '0; exp_dout = '0; exp_cnt = 0;
    check_reset_values("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("after_async_reset");

    // Randomized operations; enough of them to wrap the 8-bit counter too.
    for (int n = 0; n < 270; n++) begin
      do_op(W'($urandom), W'($urandom), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout: got=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
